// File: rtl/piso_serializer_if.sv
// Handshake and serial-stream signals of the PISO serializer.
// The slave modport is the serializer; the master modport is the word source and stream consumer.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             en;
    logic             sout;
    logic             sout_valid;
    logic             sout_first;
    logic             sout_last;

    modport master (
        output in_data, in_valid, en,
        input  in_ready, sout, sout_valid, sout_first, sout_last
    );

    modport slave (
        input  in_data, in_valid, en,
        output in_ready, sout, sout_valid, sout_first, sout_last
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: takes a WIDTH-bit word over valid/ready and
// shifts it out one bit per enabled clock with valid/first/last framing flags.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic              clk,
    input logic              rst,
    piso_serializer_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   shreg, shreg_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               at_last;
    logic               ready;
    logic               accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            shreg <= shreg_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        shreg_next = shreg;
        cnt_next   = cnt;
        at_last    = (cnt == LAST);
        // Ready also on the last enabled bit so back-to-back frames have no gap.
        ready      = rst && ((state == IDLE) || (at_last && bus.en));
        accept     = bus.in_valid && ready;

        case (state)
            IDLE: begin
                if (accept) begin
                    shreg_next = bus.in_data;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.en) begin
                    if (!at_last) begin
                        shreg_next = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                               : {1'b0, shreg[WIDTH-1:1]};
                        cnt_next   = cnt + 1'b1;
                    end else if (accept) begin
                        shreg_next = bus.in_data;
                        cnt_next   = '0;
                    end else begin
                        shreg_next = '0;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready   = ready;
    assign bus.sout_valid = (state == SHIFT);
    assign bus.sout_first = (state == SHIFT) && (cnt == '0);
    assign bus.sout_last  = (state == SHIFT) && at_last;
    assign bus.sout       = (state == SHIFT) && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first instances sharing clock and reset.
module tb_piso_serializer;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    piso_serializer_if #(.WIDTH(8)) a ();
    piso_serializer_if #(.WIDTH(8)) b ();

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst(rst), .bus(a));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst(rst), .bus(b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0]  s8;
        logic [15:0] s16;
        int          idx;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        a.in_data   = '0; a.in_valid = 1'b0; a.en = 1'b1;
        b.in_data   = '0; b.in_valid = 1'b0; b.en = 1'b1;

        // Reset state
        #1;
        chk("rst_ready", a.in_ready, 0);
        chk("rst_outs", {a.sout, a.sout_valid, a.sout_first, a.sout_last}, 4'b0000);
        tick(); tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_ready", a.in_ready, 1);
        chk("rel_valid", a.sout_valid, 0);

        // Single word 8'hA5, MSB first
        s8 = 8'b10100101;
        a.in_data = 8'hA5; a.in_valid = 1'b1;
        tick();
        a.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("single_bit", {a.sout, a.sout_valid, a.sout_first, a.sout_last},
                {s8[7-i], 1'b1, i == 0, i == 7});
            tick();
        end
        chk("single_idle", {a.sout, a.sout_valid, a.sout_first, a.sout_last}, 4'b0000);

        // Back-to-back 8'hA5 then 8'h3C
        s16 = 16'b1010010100111100;
        a.in_data = 8'hA5; a.in_valid = 1'b1;
        tick();
        a.in_data = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            chk("b2b_bit", {a.sout, a.sout_valid, a.sout_first, a.sout_last},
                {s16[15-i], 1'b1, (i == 0) || (i == 8), (i == 7) || (i == 15)});
            chk("b2b_ready", a.in_ready, (i == 7) || (i == 15));
            tick();
            if (i == 7) a.in_valid = 1'b0;
        end
        chk("b2b_idle", {a.sout, a.sout_valid}, 2'b00);

        // Stall three cycles while bit 3 is out
        a.in_data = 8'hA5; a.in_valid = 1'b1;
        tick();
        a.in_valid = 1'b0;
        for (int c = 0; c < 11; c++) begin
            a.en = !(c >= 3 && c <= 5);
            idx  = (c < 3) ? c : (c <= 6) ? 3 : c - 3;
            chk("stall_bit", {a.sout, a.sout_valid, a.sout_first, a.sout_last},
                {s8[7-idx], 1'b1, c == 0, c == 10});
            if (c == 4) chk("stall_ready", a.in_ready, 0);
            tick();
        end
        a.en = 1'b1;
        chk("stall_idle", {a.sout, a.sout_valid}, 2'b00);

        // Busy rejection of 8'h55, then en low on the last bit
        a.in_data = 8'hA5; a.in_valid = 1'b1;
        tick();
        a.in_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if (c == 2) begin
                a.in_data = 8'h55; a.in_valid = 1'b1;
            end
            if (c >= 2) chk("busy_ready", a.in_ready, 0);
            chk("busy_bit", a.sout, s8[7-c]);
            tick();
        end
        a.en = 1'b0;
        #1;
        chk("last_stall_ready", a.in_ready, 0);
        chk("last_stall_bit", {a.sout, a.sout_last}, 2'b11);
        tick();
        chk("last_held", {a.sout, a.sout_valid, a.sout_last}, 3'b111);
        a.en = 1'b1;
        #1;
        chk("last_ready", a.in_ready, 1);
        tick();
        a.in_valid = 1'b0;
        s8 = 8'b01010101;
        for (int i = 0; i < 8; i++) begin
            chk("busy_next", {a.sout, a.sout_valid, a.sout_first, a.sout_last},
                {s8[7-i], 1'b1, i == 0, i == 7});
            tick();
        end
        chk("busy_idle", a.sout_valid, 0);

        // LSB-first instance, 8'h01
        s8 = 8'b10000000;
        b.in_data = 8'h01; b.in_valid = 1'b1;
        tick();
        b.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("lsb_bit", {b.sout, b.sout_valid, b.sout_first, b.sout_last},
                {s8[7-i], 1'b1, i == 0, i == 7});
            tick();
        end
        chk("lsb_idle", b.sout_valid, 0);

        // Reset in the middle of an 8'hFF frame
        a.in_data = 8'hFF; a.in_valid = 1'b1;
        tick();
        a.in_valid = 1'b0;
        tick(); tick(); tick();
        chk("pre_abort", {a.sout, a.sout_valid, a.sout_first, a.sout_last}, 4'b1100);
        rst = 1'b0;
        #1;
        chk("abort_outs", {a.sout, a.sout_valid, a.sout_first, a.sout_last}, 4'b0000);
        chk("abort_ready", a.in_ready, 0);
        tick(); tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_rel_ready", a.in_ready, 1);
        chk("abort_rel_valid", a.sout_valid, 0);
        tick(); tick(); tick();
        chk("abort_no_resume", {a.sout, a.sout_valid}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
